// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes for memory wait, taken
// redirect, load-use and fetch stalls, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_useRs1,
    input  logic        id_useRs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_readMem,
    input  logic        ex_writeReg,
    input  logic        me_redirect,
    input  logic        me_memReq,
    input  logic        dmem_ack,
    input  logic        imem_valid,
    input  logic        stat_clr,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_me_en,
    output logic        me_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_me_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_stall_cnt;

    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_loaduse;
    logic        w_memwait;
    logic        w_redirect_evt;
    logic        w_ifetch;
    logic        w_stall;
    logic [4:0]  w_en;      // {pc, if_id, id_ex, ex_me, me_wb}
    logic [2:0]  w_flush;   // {if_id, id_ex, ex_me}

    always_comb begin
        w_rs1_hit      = id_useRs1 && (id_rs1 == ex_rd);
        w_rs2_hit      = id_useRs2 && (id_rs2 == ex_rd);
        w_loaduse      = ex_readMem && ex_writeReg && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
        // Once waiting, only the ack releases the pipeline, whatever me_memReq does.
        w_memwait      = (r_state == ST_MEM_WAIT) ? !dmem_ack : (me_memReq && !dmem_ack);
        w_redirect_evt = me_redirect && !w_memwait;
        w_ifetch       = !imem_valid;
    end

    always_comb begin
        w_en         = 5'b11111;
        w_flush      = 3'b000;
        w_state_next = ST_RUN;
        if (w_memwait) begin
            w_en         = 5'b00000;
            w_state_next = ST_MEM_WAIT;
        end else begin
            if (w_redirect_evt) begin
                w_flush      = 3'b111;
                w_state_next = ST_REDIRECT;
            end else if (w_loaduse) begin
                w_en[4]    = 1'b0;
                w_en[3]    = 1'b0;
                w_flush[1] = 1'b1;
            end else if (w_ifetch) begin
                w_en[4]    = 1'b0;
                w_flush[2] = 1'b1;
            end
            // The fetch in flight during the redirect cycle is from the wrong path.
            if (r_state == ST_REDIRECT) begin
                w_flush[2] = 1'b1;
            end
        end
        w_stall = !w_en[4] || !w_en[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (stat_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_comb begin
        pc_en       = !rst && w_en[4];
        if_id_en    = !rst && w_en[3];
        id_ex_en    = !rst && w_en[2];
        ex_me_en    = !rst && w_en[1];
        me_wb_en    = !rst && w_en[0];
        if_id_flush = rst || w_flush[2];
        id_ex_flush = rst || w_flush[1];
        ex_me_flush = rst || w_flush[0];
        state       = r_state;
        stall_cnt   = r_stall_cnt;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_useRs1 = 0, id_useRs2 = 0, ex_readMem = 0, ex_writeReg = 0;
    logic        me_redirect = 0, me_memReq = 0, dmem_ack = 0, imem_valid = 1, stat_clr = 0;
    logic        pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
    logic        if_id_flush, id_ex_flush, ex_me_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rm;
        logic       wr;
        logic       redir;
        logic       mreq;
        logic       ack;
        logic       iv;
        logic       clr;
    } in_t;

    typedef struct {
        in_t        i;
        logic [4:0] en;
        logic [2:0] fl;
        int         ns;
        int         cnt;
    } tv_t;

    tv_t tbl[13];
    int  m_state;
    int  m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
        .ex_rd(ex_rd), .ex_readMem(ex_readMem), .ex_writeReg(ex_writeReg),
        .me_redirect(me_redirect), .me_memReq(me_memReq), .dmem_ack(dmem_ack),
        .imem_valid(imem_valid), .stat_clr(stat_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_me_en(ex_me_en),
        .me_wb_en(me_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_me_flush(ex_me_flush), .state(state), .stall_cnt(stall_cnt)
    );

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit rm, input bit wr, input bit redir,
                               input bit mreq, input bit ack, input bit iv);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
        v.rm = rm; v.wr = wr; v.redir = redir; v.mreq = mreq; v.ack = ack; v.iv = iv;
        v.clr = 1'b0;
        return v;
    endfunction

    function automatic logic [4:0] get_en();
        return {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en};
    endfunction

    function automatic logic [2:0] get_fl();
        return {if_id_flush, id_ex_flush, ex_me_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_useRs1 = v.u1; id_useRs2 = v.u2;
        ex_rd = v.rd; ex_readMem = v.rm; ex_writeReg = v.wr;
        me_redirect = v.redir; me_memReq = v.mreq; dmem_ack = v.ack;
        imem_valid = v.iv; stat_clr = v.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        rst = 1'b0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    // Reference: the priority rules written out directly, state as a plain number.
    task automatic model(input int st, input in_t v, output logic [4:0] en,
                         output logic [2:0] fl, output int ns);
        bit waiting, lu;
        waiting = (st == 1) ? !v.ack : (v.mreq && !v.ack);
        lu = v.rm && v.wr && (v.rd != 0) &&
             ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (waiting)       begin en = 5'b00000; fl = 3'b000; ns = 1; end
        else if (v.redir)  begin en = 5'b11111; fl = 3'b111; ns = 2; end
        else if (lu)       begin en = 5'b00111; fl = 3'b010; ns = 0; end
        else if (!v.iv)    begin en = 5'b01111; fl = 3'b100; ns = 0; end
        else               begin en = 5'b11111; fl = 3'b000; ns = 0; end
        if (!waiting && st == 2) fl = fl | 3'b100;
    endtask

    initial begin
        in_t        idle, v;
        logic [4:0] e_en;
        logic [2:0] e_fl;
        int         e_ns;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[0]  = '{idle,                                       5'b11111, 3'b000, 0, 0};
        tbl[1]  = '{mk(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 1),        5'b00111, 3'b010, 0, 1};
        tbl[2]  = '{mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1),        5'b11111, 3'b000, 0, 0};
        tbl[3]  = '{mk(7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1),        5'b11111, 3'b000, 0, 0};
        tbl[4]  = '{mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 1),        5'b11111, 3'b000, 0, 0};
        tbl[5]  = '{mk(9, 3, 1, 1, 9, 1, 1, 0, 0, 0, 1),        5'b00111, 3'b010, 0, 1};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        5'b01111, 3'b100, 0, 1};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1),        5'b11111, 3'b111, 2, 0};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1),        5'b00000, 3'b000, 1, 1};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1),        5'b11111, 3'b000, 0, 0};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1),        5'b00000, 3'b000, 1, 1};
        tbl[11] = '{mk(4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0),        5'b00111, 3'b010, 0, 1};
        tbl[12] = '{mk(4, 0, 1, 0, 4, 1, 1, 1, 0, 0, 1),        5'b11111, 3'b111, 2, 0};

        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_en", 32'(get_en()), 32'd0);
        chk("reset_fl", 32'(get_fl()), 32'h7);

        for (int k = 0; k < 13; k++) begin
            do_reset();
            drive(tbl[k].i);
            #3;
            chk($sformatf("tbl%0d_en", k), 32'(get_en()), 32'(tbl[k].en));
            chk($sformatf("tbl%0d_fl", k), 32'(get_fl()), 32'(tbl[k].fl));
            tick();
            chk($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].ns));
            chk($sformatf("tbl%0d_cnt", k), 32'(stall_cnt), 32'(tbl[k].cnt));
        end

        // Memory wait: three stalled cycles, release on ack.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("mw%0d_en", k), 32'(get_en()), 32'd0);
            tick();
            chk($sformatf("mw%0d_state", k), 32'(state), 32'd1);
        end
        dmem_ack = 1'b1;
        #3;
        chk("mw_ack_en", 32'(get_en()), 32'h1f);
        tick();
        chk("mw_ack_state", 32'(state), 32'd0);
        chk("mw_cnt", 32'(stall_cnt), 32'd3);

        // Redirect from RUN, then the one-cycle REDIRECT state.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        #3;
        chk("rd_fl", 32'(get_fl()), 32'h7);
        tick();
        chk("rd_state", 32'(state), 32'd2);
        drive(idle);
        #3;
        chk("rd2_fl", 32'(get_fl()), 32'h4);
        chk("rd2_en", 32'(get_en()), 32'h1f);
        tick();
        chk("rd2_state", 32'(state), 32'd0);

        // Redirect coincident with a memory wait: flushes deferred to the ack cycle.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        #3;
        chk("sim_en", 32'(get_en()), 32'd0);
        chk("sim_fl", 32'(get_fl()), 32'd0);
        tick();
        chk("sim_state", 32'(state), 32'd1);
        dmem_ack = 1'b1;
        #3;
        chk("sim_ack_fl", 32'(get_fl()), 32'h7);
        chk("sim_ack_en", 32'(get_en()), 32'h1f);
        tick();
        chk("sim_ack_state", 32'(state), 32'd2);
        drive(idle);
        tick();
        chk("sim_end_state", 32'(state), 32'd0);

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tick();
        tick();
        chk("rmw_state", 32'(state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmw_rst_state", 32'(state), 32'd0);
        chk("rmw_rst_en", 32'(get_en()), 32'd0);
        chk("rmw_rst_fl", 32'(get_fl()), 32'h7);
        chk("rmw_rst_cnt", 32'(stall_cnt), 32'd0);
        drive(idle);
        tick();
        rst = 1'b0;
        #3;
        chk("rmw_post_en", 32'(get_en()), 32'h1f);
        chk("rmw_post_fl", 32'(get_fl()), 32'd0);
        tick();
        chk("rmw_post_state", 32'(state), 32'd0);
        chk("rmw_post_cnt", 32'(stall_cnt), 32'd0);

        // Saturation and clear.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (65534) tick();
        chk("sat_before", 32'(stall_cnt), 32'hFFFE);
        repeat (6) tick();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        stat_clr = 1'b1;
        tick();
        chk("clr", 32'(stall_cnt), 32'd0);
        stat_clr = 1'b0;
        imem_valid = 1'b1;
        tick();
        chk("clr_idle", 32'(stall_cnt), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.rm    = 1'($urandom_range(0, 1));
            v.wr    = ($urandom_range(0, 3) != 0);
            v.redir = ($urandom_range(0, 5) == 0);
            v.mreq  = ($urandom_range(0, 3) == 0);
            v.ack   = 1'($urandom_range(0, 1));
            v.iv    = ($urandom_range(0, 7) != 0);
            v.clr   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 149) == 0) begin
                drive(v);
                rst = 1'b1;
                #3;
                chk("rnd_rst_en", 32'(get_en()), 32'd0);
                chk("rnd_rst_fl", 32'(get_fl()), 32'h7);
                chk("rnd_rst_state", 32'(state), 32'd0);
                chk("rnd_rst_cnt", 32'(stall_cnt), 32'd0);
                tick();
                rst = 1'b0;
                m_state = 0;
                m_cnt   = 0;
            end else begin
                drive(v);
                #3;
                model(m_state, v, e_en, e_fl, e_ns);
                chk($sformatf("rnd%0d_en", k), 32'(get_en()), 32'(e_en));
                chk($sformatf("rnd%0d_fl", k), 32'(get_fl()), 32'(e_fl));
                tick();
                if (v.clr) m_cnt = 0;
                else if ((!e_en[4] || !e_en[1]) && m_cnt < 65535) m_cnt = m_cnt + 1;
                m_state = e_ns;
                chk($sformatf("rnd%0d_state", k), 32'(state), 32'(m_state));
                chk($sformatf("rnd%0d_cnt", k), 32'(stall_cnt), 32'(m_cnt));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_useRs1, id_useRs2  input  1 each  ID instruction actually reads rs1 or rs2.
REQ-006 ex_rd  input  5  destination register of the instruction in EX.
REQ-007 ex_readMem, ex_writeReg  input  1 each  EX instruction is a load, or writes the register file.
REQ-008 me_redirect  input  1  branch or jump resolved taken in ME.
REQ-009 me_memReq  input  1  ME instruction accesses data memory this cycle.
REQ-010 dmem_ack  input  1  data memory completes the ME access this cycle.
REQ-011 imem_valid  input  1  fetched instruction is valid this cycle.
REQ-012 stat_clr  input  1  synchronous clear of stall_cnt.
REQ-013 pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en  output  1 each  stage register enables (pipeline_en).
REQ-014 if_id_flush, id_ex_flush, ex_me_flush  output  1 each  stage register flush; each flush overrides its enable in the stage register.
REQ-015 state  output  2  current FSM state: RUN=0, MEM_WAIT=1, REDIRECT=2.
REQ-016 stall_cnt  output  16  count of stall cycles.

Function
REQ-017 State, stall_cnt: registers; all other outputs: combinational from state and current inputs, same-cycle.
REQ-018 Defaults unless overridden: all enables 1, all flushes 0.
REQ-019 Priority, highest first: MEMWAIT > REDIRECT_EVT > LOADUSE > IFETCH.
REQ-020 MEMWAIT = me_memReq && !dmem_ack, in RUN or REDIRECT.
  - All five enables 0.
  - All flushes 0.
  - Next state MEM_WAIT.
REQ-021 MEM_WAIT with dmem_ack=0: all enables 0, all flushes 0, stay.
REQ-022 MEM_WAIT with dmem_ack=1: outputs evaluated exactly as RUN with MEMWAIT false; next state per REQ-023/REQ-027.
REQ-023 REDIRECT_EVT = me_redirect with MEMWAIT false.
  - All enables 1.
  - if_id_flush = id_ex_flush = ex_me_flush = 1.
  - Next state REDIRECT.
REQ-024 LOADUSE = ex_readMem && ex_writeReg && ex_rd!=0 && ((id_useRs1 && id_rs1==ex_rd) || (id_useRs2 && id_rs2==ex_rd)).
  - pc_en = 0, if_id_en = 0.
  - id_ex_flush = 1 (bubble); id_ex_en, ex_me_en, me_wb_en = 1.
REQ-025 IFETCH = !imem_valid with no higher event: pc_en = 0, if_id_flush = 1, remaining stages run.
REQ-026 REDIRECT state lasts one cycle: if_id_flush forced 1 (discards stale in-flight fetch) in addition to REQ-019 evaluation; next state RUN unless MEMWAIT or REDIRECT_EVT.
REQ-027 No event in RUN or REDIRECT: next state RUN.
REQ-028 A register index of 0 never causes LOADUSE.
REQ-029 stall_cnt increments by 1 each cycle in which pc_en=0 or ex_me_en=0; saturates at 16'hFFFF.
REQ-030 stat_clr=1: stall_cnt <= 0 next edge, overriding increment.
REQ-031 Illegal state encoding 3: behave as RUN; next state RUN.

Reset
REQ-032 While rst=1, regardless of clk:
  - state = RUN, stall_cnt = 0.
  - All enables 0, all three flushes 1.
REQ-033 rst asserted mid MEM_WAIT or REDIRECT: immediate return to RUN; no pending stall or flush survives deassertion.
REQ-034 First cycle after deassertion evaluates as RUN with current inputs.

Verification
REQ-035 Load-use: ex_readMem=1, ex_writeReg=1, ex_rd=5, id_rs2=5, id_useRs2=1 -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt +1.
REQ-036 Memory wait: me_memReq=1, dmem_ack=0 for 3 cycles, then dmem_ack=1.
  - state = MEM_WAIT for 3 cycles with all enables 0.
  - Enables 1 on the ack cycle; RUN next.
  - stall_cnt +3.
REQ-037 Redirect: me_redirect=1 in RUN -> three flushes 1 that cycle, state=2 next, if_id_flush=1 in that cycle, then state=0.
REQ-038 Simultaneous events: me_redirect=1, me_memReq=1, dmem_ack=0 -> MEM_WAIT, no flush; redirect flushes fire on the ack cycle.
REQ-039 Boundary checks:
  - ex_rd=0 matching id_rs1 -> no stall.
  - stall_cnt preloaded to 16'hFFFF by stalls -> remains 16'hFFFF.
  - stat_clr -> 0.
REQ-040 Reset mid-wait: rst pulse during MEM_WAIT -> state=0, enables 0, flushes 1 immediately; after release, no stall with idle inputs.
